// File: rtl/wb_pkg.sv
// Shared definitions for the writeback-select stage: load sizes, FSM states
// and the default source-index map.
package wb_pkg;

  // Load size encodings as driven on in_mem_size
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_FULL = 2'b11
  } load_size_e;

  // Stage control states
  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_MEM = 1'b1
  } state_e;

  // Default writeback source indices
  localparam int unsigned SRC_ALU  = 0;
  localparam int unsigned SRC_MEM  = 1;
  localparam int unsigned SRC_LINK = 2;
  localparam int unsigned SRC_LUI  = 3;

endpackage

// File: rtl/wb_load_align.sv
// Little-endian load extraction: picks the byte/half/word/full lane from the
// memory word and sign- or zero-extends it to DATA_W. Purely combinational.
module wb_load_align
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0]             data_i,
  input  load_size_e                    size_i,
  input  logic                          unsigned_i,
  input  logic [$clog2(DATA_W/8)-1:0]   addr_lo_i,
  output logic [DATA_W-1:0]             aligned_o_c
);

  localparam int unsigned AW = $clog2(DATA_W/8);

  logic [AW-1:0]     lane_c;
  logic [DATA_W-1:0] shifted_c;
  logic [DATA_W-1:0] mask_c;
  logic              sign_c;

  // Lane selection: low address bits below the access size are ignored
  always_comb begin
    lane_c = '0;
    unique case (size_i)
      SZ_BYTE: lane_c = addr_lo_i;
      SZ_HALF: lane_c = {addr_lo_i[AW-1:1], 1'b0};
      SZ_WORD: lane_c = addr_lo_i & ~AW'(3);
      SZ_FULL: lane_c = '0;
      default: lane_c = '0;
    endcase
  end

  assign shifted_c = data_i >> {lane_c, 3'b000};

  // Field mask and sign bit; a 32-bit word on a 32-bit datapath is the full word
  always_comb begin
    mask_c = '1;
    sign_c = 1'b0;
    unique case (size_i)
      SZ_BYTE: begin mask_c = DATA_W'(8'hFF);         sign_c = shifted_c[7];  end
      SZ_HALF: begin mask_c = DATA_W'(16'hFFFF);      sign_c = shifted_c[15]; end
      SZ_WORD: begin mask_c = DATA_W'(32'hFFFF_FFFF); sign_c = shifted_c[31]; end
      SZ_FULL: begin mask_c = '1;                     sign_c = 1'b0;          end
      default: begin mask_c = '1;                     sign_c = 1'b0;          end
    endcase
  end

  assign aligned_o_c = (shifted_c & mask_c) |
                       ((sign_c && !unsigned_i) ? ~mask_c : '0);

endmodule

// File: rtl/wb_select_stage.sv
// Registered N-source writeback select for the MIPS datapath. Loads from the
// memory source are aligned/extended; a not-ready memory source parks the
// stage in WAIT_MEM until read data arrives.
// Optional: define WB_STALL_COUNT_EN to add the saturating out_stall_cycles counter.
module wb_select_stage
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned MEM_SRC    = SRC_MEM,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                          in_clk,
  input  logic                          in_rst,
  input  logic                          in_valid,
  input  logic [$clog2(NUM_SRC)-1:0]    in_select,
  input  logic [NUM_SRC*DATA_W-1:0]     in_src_data,
  input  logic [REG_ADDR_W-1:0]         in_reg_addr,
  input  logic [1:0]                    in_mem_size,
  input  logic                          in_mem_unsigned,
  input  logic [$clog2(DATA_W/8)-1:0]   in_mem_addr_lo,
  input  logic                          in_mem_ready,
  output logic                          out_stall,
  output logic                          out_wb_valid,
  output logic                          out_wb_we,
  output logic [REG_ADDR_W-1:0]         out_wb_reg,
  output logic [DATA_W-1:0]             out_wb_data
`ifdef WB_STALL_COUNT_EN
  ,
  output logic [31:0]                   out_stall_cycles
`endif
);

  localparam int unsigned SEL_W   = $clog2(NUM_SRC);
  localparam int unsigned AW      = $clog2(DATA_W/8);
  localparam int unsigned SEL_NUM = 2**SEL_W;

  state_e                  state_q;
  logic                    stall_q;
  logic                    wb_valid_q;
  logic                    wb_we_q;
  logic [REG_ADDR_W-1:0]   wb_reg_q;
  logic [DATA_W-1:0]       wb_data_q;

  // Fields of a load parked while waiting for memory
  logic [REG_ADDR_W-1:0]   p_reg_q;
  load_size_e              p_size_q;
  logic                    p_uns_q;
  logic [AW-1:0]           p_addr_q;

  logic [DATA_W-1:0]       src_arr [SEL_NUM];
  logic [DATA_W-1:0]       sel_data_c;
  logic [DATA_W-1:0]       mem_data_c;
  logic [DATA_W-1:0]       aligned_c;
  logic                    is_mem_c;
  load_size_e              al_size_c;
  logic                    al_uns_c;
  logic [AW-1:0]           al_addr_c;

  // Unpack sources; indices beyond NUM_SRC read as zero
  for (genvar k = 0; k < SEL_NUM; k++) begin : g_src
    if (k < NUM_SRC) begin : g_real
      assign src_arr[k] = in_src_data[k*DATA_W +: DATA_W];
    end else begin : g_pad
      assign src_arr[k] = '0;
    end
  end

  assign sel_data_c = src_arr[in_select];
  assign mem_data_c = in_src_data[MEM_SRC*DATA_W +: DATA_W];
  assign is_mem_c   = (in_select == SEL_W'(MEM_SRC));

  // Alignment controls come from the live request in IDLE, from the parked load otherwise
  always_comb begin
    al_size_c = load_size_e'(in_mem_size);
    al_uns_c  = in_mem_unsigned;
    al_addr_c = in_mem_addr_lo;
    if (state_q == ST_WAIT_MEM) begin
      al_size_c = p_size_q;
      al_uns_c  = p_uns_q;
      al_addr_c = p_addr_q;
    end
  end

  wb_load_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .data_i      (mem_data_c),
    .size_i      (al_size_c),
    .unsigned_i  (al_uns_c),
    .addr_lo_i   (al_addr_c),
    .aligned_o_c (aligned_c)
  );

  // Control FSM with registered writeback port and stall flag
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q    <= ST_IDLE;
      stall_q    <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_reg_q   <= '0;
      wb_data_q  <= '0;
      p_reg_q    <= '0;
      p_size_q   <= SZ_BYTE;
      p_uns_q    <= 1'b0;
      p_addr_q   <= '0;
    end else begin
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            if (is_mem_c && !in_mem_ready) begin
              p_reg_q  <= in_reg_addr;
              p_size_q <= load_size_e'(in_mem_size);
              p_uns_q  <= in_mem_unsigned;
              p_addr_q <= in_mem_addr_lo;
              state_q  <= ST_WAIT_MEM;
              stall_q  <= 1'b1;
            end else begin
              wb_valid_q <= 1'b1;
              wb_we_q    <= |in_reg_addr;
              wb_reg_q   <= in_reg_addr;
              wb_data_q  <= is_mem_c ? aligned_c : sel_data_c;
            end
          end
        end
        ST_WAIT_MEM: begin
          if (in_mem_ready) begin
            wb_valid_q <= 1'b1;
            wb_we_q    <= |p_reg_q;
            wb_reg_q   <= p_reg_q;
            wb_data_q  <= aligned_c;
            state_q    <= ST_IDLE;
            stall_q    <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          stall_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_stall    = stall_q;
  assign out_wb_valid = wb_valid_q;
  assign out_wb_we    = wb_we_q;
  assign out_wb_reg   = wb_reg_q;
  assign out_wb_data  = wb_data_q;

`ifdef WB_STALL_COUNT_EN
  logic [31:0] stall_cnt_q;

  // Saturating count of cycles spent stalled
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      stall_cnt_q <= '0;
    end else if (stall_q && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign out_stall_cycles = stall_cnt_q;
`endif

endmodule

// File: doc/wb_select_stage.md
Name: wb_select_stage

Overview:
- Registered, parametrised writeback-select stage for the MIPS datapath. Generalises the 2:1 memory/ALU writeback mux to NUM_SRC sources.
- Load data from data memory passes through byte/halfword/word extraction with sign or zero extension.
- A memory source that is not ready stalls the stage in a wait state until read data returns.
- Output drives the register-file write port one cycle after acceptance.

Parameters:
- DATA_W, 32, datapath width; legal values 32 or 64.
- NUM_SRC, 4, number of writeback sources (2..8).
- MEM_SRC, 1, index of the data-memory source within in_src_data.
- REG_ADDR_W, 5, register address width.

Ports:
- in_clk  input  1  clock; rising edge.
- in_rst  input  1  synchronous, active-high reset.
- in_valid  input  1  writeback request present.
- in_select  input  $clog2(NUM_SRC)  source index.
- in_src_data  input  NUM_SRC*DATA_W  packed source data; source k at bits [k*DATA_W +: DATA_W].
- in_reg_addr  input  REG_ADDR_W  destination register.
- in_mem_size  input  2  load size: 00 byte, 01 half, 10 word (32-bit), 11 full DATA_W.
- in_mem_unsigned  input  1  1 = zero-extend, 0 = sign-extend.
- in_mem_addr_lo  input  $clog2(DATA_W/8)  low byte-address bits of the load.
- in_mem_ready  input  1  memory read data valid this cycle.
- out_stall  output  1  stage busy; upstream holds its request.
- out_wb_valid  output  1  writeback result valid; one-cycle pulse per request.
- out_wb_we  output  1  register-file write enable.
- out_wb_reg  output  REG_ADDR_W  destination register.
- out_wb_data  output  DATA_W  aligned, extended writeback data.

Behaviour:
- States: IDLE, WAIT_MEM.
- out_stall = (state == WAIT_MEM). It is registered-state derived and has no combinational path from inputs.
- IDLE, in_valid=1, in_select≠MEM_SRC: the selected source is registered. Next cycle: out_wb_valid=1. Latency is 1.
- IDLE, in_valid=1, in_select=MEM_SRC, in_mem_ready=1: aligned data is registered. Latency is 1 and the state stays IDLE.
- IDLE, in_valid=1, in_select=MEM_SRC, in_mem_ready=0: capture reg_addr, size, unsigned and addr_lo, then go to WAIT_MEM. No output is produced.
- WAIT_MEM: in_valid is ignored. When in_mem_ready=1, align the memory source data using the captured fields. Next cycle: out_wb_valid=1 and the state returns to IDLE.
- There is no timeout.
- in_select ≥ NUM_SRC: the request is treated as a non-memory request with data 0.
- Alignment is little-endian.
  - Byte: lane = addr_lo.
  - Half: lane = {addr_lo[msb:1], 0}; addr_lo[0] is ignored.
  - Word: lane = addr_lo aligned to 4 bytes.
  - Full: addr_lo is ignored.
  - The extracted field is then sign- or zero-extended to DATA_W.
  - Size 11 with DATA_W=32 equals size 10.
- Non-memory sources pass through unmodified; the size and unsigned fields are ignored.
- out_wb_we = out_wb_valid && (out_wb_reg ≠ 0). Register 0 is never written, but out_wb_valid still pulses.
- out_wb_data and out_wb_reg hold their last value while out_wb_valid=0.
- Reset values: state=IDLE, out_stall=0, out_wb_valid=0, out_wb_we=0, out_wb_reg=0, out_wb_data=0.
- Reset during WAIT_MEM drops the pending load with no writeback. A reset cycle overrides a simultaneous in_valid.
- Back-to-back non-memory requests on consecutive cycles give consecutive valid pulses with no bubbles.

Optional Feature:
- Macro: WB_STALL_COUNT_EN.
- Defined: adds output out_stall_cycles (32 bits). It increments every cycle out_stall=1, saturates at 0xFFFFFFFF, and is cleared by in_rst.
- Undefined: the port and the counter are absent. All other behaviour is identical.

Decomposition:
- Shared package wb_pkg holds:
  - load-size encodings: SZ_BYTE, SZ_HALF, SZ_WORD, SZ_FULL;
  - state enum: ST_IDLE, ST_WAIT_MEM;
  - default source index constants: SRC_ALU=0, SRC_MEM=1, SRC_LINK=2, SRC_LUI=3.
- One natural sub-module, wb_load_align: purely combinational extraction and extension of (data, size, unsigned, addr_lo), instantiated once.

Test Plan:
- ALU source: select=0, src0=0x12345678, reg=5 -> next cycle valid=1, we=1, reg=5, data=0x12345678.
- Signed byte load, ready: select=1, mem=0x80FF7F01, size=00, addr_lo=3, unsigned=0 -> data=0xFFFFFF80. Same with unsigned=1 -> 0x00000080.
- Halfword load: mem=0x80FF7F01, size=01, addr_lo=2, signed -> 0xFFFF80FF. addr_lo=1 -> 0x00007F01.
- Stalled load: select=1, ready=0 for 3 cycles -> out_stall=1 for 3 cycles, no valid. A new in_valid held during the stall is not accepted. Ready=1 with mem=0x00000042, byte, addr 0 -> valid next cycle, data=0x42, stall drops.
- Register 0 destination: reg=0, ALU data 0xDEADBEEF -> valid=1, we=0.
- Reset in WAIT_MEM: assert in_rst while stalled -> no writeback ever appears, stall=0 next cycle. With WB_STALL_COUNT_EN defined: count reads 0 after reset, and reads 3 after the stalled-load scenario.
